// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin, burst-bounded sharing of one BRAM port between two requesters
module bram_port_arbiter #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 64,
    parameter int C_MAX_BURST  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rq0_valid,
    output logic                      rq0_ready,
    input  logic                      rq0_we,
    input  logic [C_ADDR_WIDTH-1:0]   rq0_addr,
    input  logic [C_DATA_WIDTH-1:0]   rq0_wdata,
    input  logic                      rq1_valid,
    output logic                      rq1_ready,
    input  logic                      rq1_we,
    input  logic [C_ADDR_WIDTH-1:0]   rq1_addr,
    input  logic [C_DATA_WIDTH-1:0]   rq1_wdata,
    output logic                      rs0_valid,
    output logic [C_DATA_WIDTH-1:0]   rs0_data,
    output logic                      rs1_valid,
    output logic [C_DATA_WIDTH-1:0]   rs1_data,
    output logic [C_ADDR_WIDTH-1:0]   bram_addr,
    output logic [C_DATA_WIDTH-1:0]   bram_din,
    output logic                      bram_en,
    output logic [C_DATA_WIDTH/8-1:0] bram_we,
    input  logic [C_DATA_WIDTH-1:0]   bram_dout
);

    localparam int WE_W = C_DATA_WIDTH / 8;

    logic       last;
    logic [7:0] burst_cnt;

    logic                    gnt_id;
    logic                    accept;
    logic                    sel_we;
    logic [C_ADDR_WIDTH-1:0] sel_addr;
    logic [C_DATA_WIDTH-1:0] sel_wdata;

    // read tag pipeline: tag1 travels with the bram_* command, tag2 with bram_dout
    logic tag1_valid, tag1_id;
    logic tag2_valid, tag2_id;

    always_comb begin
        accept = (rq0_valid | rq1_valid) & ~reset;
        gnt_id = rq1_valid;
        if (rq0_valid & rq1_valid) begin
            gnt_id = (burst_cnt < 8'(C_MAX_BURST)) ? last : ~last;
        end
        sel_we    = gnt_id ? rq1_we    : rq0_we;
        sel_addr  = gnt_id ? rq1_addr  : rq0_addr;
        sel_wdata = gnt_id ? rq1_wdata : rq0_wdata;
    end

    assign rq0_ready = accept & ~gnt_id;
    assign rq1_ready = accept & gnt_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= 1'b1;
            burst_cnt <= 8'd0;
        end else if (accept) begin
            if (gnt_id == last) begin
                burst_cnt <= (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
            end else begin
                last      <= gnt_id;
                burst_cnt <= 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            tag1_valid <= 1'b0;
            tag1_id    <= 1'b0;
        end else begin
            bram_en    <= accept;
            bram_we    <= {WE_W{accept & sel_we}};
            tag1_valid <= accept & ~sel_we;
            tag1_id    <= gnt_id;
            if (accept) begin
                bram_addr <= sel_addr;
                bram_din  <= sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag2_valid <= 1'b0;
            tag2_id    <= 1'b0;
            rs0_valid  <= 1'b0;
            rs1_valid  <= 1'b0;
            rs0_data   <= '0;
            rs1_data   <= '0;
        end else begin
            tag2_valid <= tag1_valid;
            tag2_id    <= tag1_id;
            rs0_valid  <= tag2_valid & ~tag2_id;
            rs1_valid  <= tag2_valid & tag2_id;
            if (tag2_valid & ~tag2_id) rs0_data <= bram_dout;
            if (tag2_valid & tag2_id)  rs1_data <= bram_dout;
        end
    end

endmodule
